// File: rtl/seg7_pkg.sv
// Shared constants and the active-low hex-to-segment table for the 7-segment scan driver.
// Segment order is {g,f,e,d,c,b,a}, with segment a in bit 0.
package seg7_pkg;

   localparam int         DIGITS  = 8;
   localparam logic [7:0] SEG_OFF = 8'hFF;
   localparam logic [7:0] AN_OFF  = 8'hFF;

   function automatic logic [6:0] hex7(input logic [3:0] nib);
      logic [6:0] seg_s;
      case (nib)
         4'h0:    seg_s = 7'h40;
         4'h1:    seg_s = 7'h79;
         4'h2:    seg_s = 7'h24;
         4'h3:    seg_s = 7'h30;
         4'h4:    seg_s = 7'h19;
         4'h5:    seg_s = 7'h12;
         4'h6:    seg_s = 7'h02;
         4'h7:    seg_s = 7'h78;
         4'h8:    seg_s = 7'h00;
         4'h9:    seg_s = 7'h10;
         4'hA:    seg_s = 7'h08;
         4'hB:    seg_s = 7'h03;
         4'hC:    seg_s = 7'h46;
         4'hD:    seg_s = 7'h21;
         4'hE:    seg_s = 7'h06;
         4'hF:    seg_s = 7'h0E;
         default: seg_s = 7'h7F;
      endcase
      return seg_s;
   endfunction

endpackage

// File: rtl/seg7_hex_dec.sv
// Combinational nibble-to-segment decoder.
// The output is active-low, with segment a in bit 0.
module seg7_hex_dec
   import seg7_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);

   // decode the currently selected digit nibble
   always_comb begin
      seg = hex7(nib);
   end

endmodule

// File: rtl/seg7_scan_drv.sv
// Scans an 8-digit common-anode display with frame-synchronous latching and blinking.
// Digit 0 is the rightmost digit.
module seg7_scan_drv
   import seg7_pkg::*;
#(
   parameter int SCAN_PERIOD  = 50000,
   parameter int BLINK_FRAMES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        EN,
   input  logic [31:0] Disp_num,
   input  logic [7:0]  point_in,
   input  logic [7:0]  LE_in,
   output logic [7:0]  AN,
   output logic [7:0]  SEGMENT,
   output logic        frame_tick
);

   localparam int              PW         = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
   localparam int              BW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [PW-1:0]   PRESC_LAST = PW'(SCAN_PERIOD - 1);
   localparam logic [BW-1:0]   BLINK_LAST = BW'(BLINK_FRAMES - 1);
   localparam logic [2:0]      LAST_DIGIT = 3'(DIGITS - 1);

   logic [PW-1:0] presc_r;
   logic [2:0]    digit_r;
   logic [31:0]   num_r;
   logic [7:0]    point_r;
   logic [7:0]    le_r;
   logic [BW-1:0] blink_cnt_r;
   logic          blink_phase_r;
   logic          new_frame_r;
   logic [7:0]    an_r;
   logic [7:0]    seg_r;
   logic          tick_r;

   logic          step_s;
   logic          boundary_s;
   logic [3:0]    nibble_s;
   logic [6:0]    hex_s;
   logic [7:0]    seg_next_s;
   logic [7:0]    an_next_s;

   // scan timing strobes and digit nibble selection
   always_comb begin
      step_s     = (presc_r == PRESC_LAST);
      boundary_s = step_s && (digit_r == LAST_DIGIT);
      nibble_s   = num_r[{digit_r, 2'b00} +: 4];
      an_next_s  = ~(8'd1 << digit_r);
   end

   seg7_hex_dec u_hex_dec (
      .nib (nibble_s),
      .seg (hex_s)
   );

   // blanked digits keep their anode on so every digit has the same duty cycle
   always_comb begin
      if (blink_phase_r && le_r[digit_r]) begin
         seg_next_s = SEG_OFF;
      end else begin
         seg_next_s = {~point_r[digit_r], hex_s};
      end
   end

   // per-digit prescaler
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc_r <= '0;
      end else if (step_s) begin
         presc_r <= '0;
      end else begin
         presc_r <= presc_r + PW'(1);
      end
   end

   // digit counter, wraps naturally mod 8
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         digit_r <= 3'd0;
      end else if (step_s) begin
         digit_r <= digit_r + 3'd1;
      end
   end

   // frame latch: values change only as digit 7 hands over to digit 0
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         num_r   <= 32'd0;
         point_r <= 8'd0;
         le_r    <= 8'd0;
      end else if (boundary_s && EN) begin
         num_r   <= Disp_num;
         point_r <= point_in;
         le_r    <= LE_in;
      end
   end

   // blink frame counter and on/off phase
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         blink_cnt_r   <= '0;
         blink_phase_r <= 1'b0;
      end else if (boundary_s) begin
         if (blink_cnt_r == BLINK_LAST) begin
            blink_cnt_r   <= '0;
            blink_phase_r <= ~blink_phase_r;
         end else begin
            blink_cnt_r <= blink_cnt_r + BW'(1);
         end
      end
   end

   // registered outputs; tick is delayed one cycle so it aligns with the first AN=FE of a frame
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         an_r        <= AN_OFF;
         seg_r       <= SEG_OFF;
         new_frame_r <= 1'b0;
         tick_r      <= 1'b0;
      end else begin
         an_r        <= an_next_s;
         seg_r       <= seg_next_s;
         new_frame_r <= boundary_s;
         tick_r      <= new_frame_r;
      end
   end

   assign AN         = an_r;
   assign SEGMENT    = seg_r;
   assign frame_tick = tick_r;

endmodule
